// File: rtl/ha_resp_checker.sv
// rtl/ha_resp_checker.sv - response checker for a bitwise half-adder DUT
// Delays applied operands by LAT cycles and scores DUT sum/carry against a^b / a&b.
module ha_resp_checker #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic [WIDTH-1:0] dut_carry,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_sum_err,
  output logic [WIDTH-1:0] first_fail_carry_err
);

  typedef enum logic [1:0] {IDLE, CHECK, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             cmp_v;
  logic             cmp_en;
  logic             pend;
  logic             match;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic [WIDTH-1:0] sum_err, carry_err;
  logic [CNT_W-1:0] txn_idx;

  assign accept = in_valid && (state == CHECK);

  generate
    if (LAT == 0) begin : g_live
      assign cmp_v = accept;
      assign cmp_a = in_a;
      assign cmp_b = in_b;
      assign pend  = 1'b0;
    end else begin : g_dl
      logic [LAT-1:0]   dl_v;
      logic [WIDTH-1:0] dl_a [LAT];
      logic [WIDTH-1:0] dl_b [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dl_v <= '0;
          for (int i = 0; i < LAT; i++) begin
            dl_a[i] <= '0;
            dl_b[i] <= '0;
          end
        end else begin
          for (int i = LAT - 1; i > 0; i--) begin
            dl_v[i] <= dl_v[i-1];
            dl_a[i] <= dl_a[i-1];
            dl_b[i] <= dl_b[i-1];
          end
          dl_v[0] <= accept;
          dl_a[0] <= in_a;
          dl_b[0] <= in_b;
          if (start) dl_v <= '0;
        end
      end

      // The last stage is being compared this cycle; only earlier stages keep DRAIN alive.
      always_comb begin
        pend = 1'b0;
        for (int i = 0; i < LAT - 1; i++) pend = pend | dl_v[i];
      end

      assign cmp_v = dl_v[LAT-1];
      assign cmp_a = dl_a[LAT-1];
      assign cmp_b = dl_b[LAT-1];
    end
  endgenerate

  assign sum_err   = dut_sum ^ (cmp_a ^ cmp_b);
  assign carry_err = dut_carry ^ (cmp_a & cmp_b);
  assign match     = (sum_err == '0) && (carry_err == '0);
  assign cmp_en    = cmp_v && ((state == CHECK) || (state == DRAIN));

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = CHECK;
    end else begin
      case (state)
        CHECK:   if (stop) state_nxt = (LAT == 0) ? DONE : DRAIN;
        DRAIN:   if (!pend) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state == CHECK) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt             <= '0;
      fail_cnt             <= '0;
      txn_idx              <= '0;
      first_fail_valid     <= 1'b0;
      first_fail_idx       <= '0;
      first_fail_sum_err   <= '0;
      first_fail_carry_err <= '0;
    end else if (start) begin
      pass_cnt             <= '0;
      fail_cnt             <= '0;
      txn_idx              <= '0;
      first_fail_valid     <= 1'b0;
      first_fail_idx       <= '0;
      first_fail_sum_err   <= '0;
      first_fail_carry_err <= '0;
    end else if (cmp_en) begin
      if (match) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        if (!first_fail_valid) begin
          first_fail_valid     <= 1'b1;
          first_fail_idx       <= txn_idx;
          first_fail_sum_err   <= sum_err;
          first_fail_carry_err <= carry_err;
        end
      end
      if (txn_idx != '1) txn_idx <= txn_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_ha_resp_checker.sv
// tb/tb_ha_resp_checker.sv - scoreboard bench for ha_resp_checker
// Three checker instances (LAT=1, LAT=3, CNT_W=4) share stimulus; results are scored on done.
module tb_ha_resp_checker;

  typedef struct {
    logic [15:0] pcnt;
    logic [15:0] fcnt;
    logic        ffv;
    logic [15:0] idx;
    logic [7:0]  serr;
    logic [7:0]  cerr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       fault = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  // Behavioural half-adder DUTs; c1f has carry bit 0 stuck at 0 while fault is set.
  logic [7:0] s1, c1, c1f;
  logic [7:0] s3 [3];
  logic [7:0] c3 [3];
  always @(posedge clk) begin
    s1    <= in_a ^ in_b;
    c1    <= in_a & in_b;
    c1f   <= (in_a & in_b) & (fault ? 8'hFE : 8'hFF);
    s3[0] <= in_a ^ in_b;
    c3[0] <= in_a & in_b;
    s3[1] <= s3[0];
    c3[1] <= c3[0];
    s3[2] <= s3[1];
    c3[2] <= c3[1];
  end

  logic        b1, d1, v1, b3, d3, v3, b4, d4, v4;
  logic [15:0] p1, f1, i1, p3, f3, i3;
  logic [3:0]  p4, f4, i4;
  logic [7:0]  se1, ce1, se3, ce3, se4, ce4;

  ha_resp_checker #(.WIDTH(8), .LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .dut_sum(s1), .dut_carry(c1f),
    .busy(b1), .done(d1), .pass_cnt(p1), .fail_cnt(f1), .first_fail_valid(v1),
    .first_fail_idx(i1), .first_fail_sum_err(se1), .first_fail_carry_err(ce1));

  ha_resp_checker #(.WIDTH(8), .LAT(3), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .dut_sum(s3[2]), .dut_carry(c3[2]),
    .busy(b3), .done(d3), .pass_cnt(p3), .fail_cnt(f3), .first_fail_valid(v3),
    .first_fail_idx(i3), .first_fail_sum_err(se3), .first_fail_carry_err(ce3));

  ha_resp_checker #(.WIDTH(8), .LAT(1), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .dut_sum(s1), .dut_carry(c1),
    .busy(b4), .done(d4), .pass_cnt(p4), .fail_cnt(f4), .first_fail_valid(v4),
    .first_fail_idx(i4), .first_fail_sum_err(se4), .first_fail_carry_err(ce4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic exp_t mk(input int p, input int f, input int v, input int idx,
                              input int s, input int c);
    exp_t e;
    e.pcnt = 16'(p);
    e.fcnt = 16'(f);
    e.ffv  = 1'(v);
    e.idx  = 16'(idx);
    e.serr = 8'(s);
    e.cerr = 8'(c);
    return e;
  endfunction

  task automatic cmp_rec(input string tag, input exp_t act, input exp_t e);
    chk({tag, "_pass_cnt"}, 32'(act.pcnt), 32'(e.pcnt));
    chk({tag, "_fail_cnt"}, 32'(act.fcnt), 32'(e.fcnt));
    chk({tag, "_ff_valid"}, 32'(act.ffv), 32'(e.ffv));
    chk({tag, "_ff_idx"}, 32'(act.idx), 32'(e.idx));
    chk({tag, "_ff_sum_err"}, 32'(act.serr), 32'(e.serr));
    chk({tag, "_ff_carry_err"}, 32'(act.cerr), 32'(e.cerr));
  endtask

  task automatic push_all(input exp_t e1, input exp_t e3, input exp_t e4);
    q1.push_back(e1);
    q3.push_back(e3);
    q4.push_back(e4);
  endtask

  // Monitors: score each instance when its done rises.
  logic pd1 = 1'b0, pd3 = 1'b0, pd4 = 1'b0;
  always @(negedge clk) begin
    pd1 <= d1;
    pd3 <= d3;
    pd4 <= d4;
    if (d1 && !pd1) begin
      chk("u1_expect_pending", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) cmp_rec("u1", mk(p1, f1, v1, i1, se1, ce1), q1.pop_front());
    end
    if (d3 && !pd3) begin
      chk("u3_expect_pending", 32'(q3.size() != 0), 1);
      if (q3.size() != 0) cmp_rec("u3", mk(p3, f3, v3, i3, se3, ce3), q3.pop_front());
    end
    if (d4 && !pd4) begin
      chk("u4_expect_pending", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) cmp_rec("u4", mk(p4, f4, v4, i4, se4, ce4), q4.pop_front());
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!(d1 && d3 && d4) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, 32'(d1 && d3 && d4), 1);
    @(negedge clk);
  endtask

  task automatic four_txns();
    txn(8'h01, 8'h10);
    txn(8'h10, 8'h01);
    txn(8'hFF, 8'hFF);
    txn(8'h00, 8'h00);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(b1), 0);
    chk("rst_done", 32'(d1), 0);
    chk("rst_pass", 32'(p1), 0);
    chk("rst_fail", 32'(f1), 0);
    chk("rst_ffv", 32'(v1), 0);
    chk("rst_ff_fields", 32'(i1 | 16'(se1) | 16'(ce1)), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct DUT, four transactions, one drain cycle at LAT=1.
    push_all(mk(4, 0, 0, 0, 0, 0), mk(4, 0, 0, 0, 0, 0), mk(4, 0, 0, 0, 0, 0));
    pulse_start();
    four_txns();
    pulse_stop();
    chk("a_u1_drain_busy", 32'(b1), 1);
    chk("a_u1_drain_not_done", 32'(d1), 0);
    @(negedge clk);
    chk("a_u1_done_after_drain", 32'(d1), 1);
    wait_done("a");

    // Carry bit 0 stuck at 0 on u1: FF/FF (index 2) fails.
    push_all(mk(3, 1, 1, 2, 8'h00, 8'h01), mk(4, 0, 0, 0, 0, 0), mk(4, 0, 0, 0, 0, 0));
    fault = 1'b1;
    pulse_start();
    four_txns();
    pulse_stop();
    fault = 1'b0;
    wait_done("b");

    // LAT=3: txn then stop, extra valids during DRAIN are ignored.
    push_all(mk(1, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0));
    pulse_start();
    txn(8'h3C, 8'h0F);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    in_valid = 1'b1;
    in_a = 8'hAA;
    in_b = 8'h55;
    chk("c_u3_drain_busy", 32'(b3), 1);
    chk("c_u3_not_done_1", 32'(d3), 0);
    @(negedge clk);
    in_a = 8'h12;
    in_b = 8'h34;
    chk("c_u3_not_done_2", 32'(d3), 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("c_u3_done_3_after_stop", 32'(d3), 1);
    wait_done("c");

    // 20 matching txns: u4 saturates at 4'hF.
    push_all(mk(20, 0, 0, 0, 0, 0), mk(20, 0, 0, 0, 0, 0), mk(15, 0, 0, 0, 0, 0));
    pulse_start();
    for (int i = 0; i < 20; i++) txn(8'(i * 37 + 3), 8'(i * 91 + 7));
    pulse_stop();
    wait_done("d");

    // Async reset mid-CHECK with two txns in flight on u3.
    pulse_start();
    txn(8'h81, 8'h7E);
    in_valid = 1'b1;
    in_a = 8'hC3;
    in_b = 8'h3C;
    #1;
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    chk("e_u3_busy", 32'(b3), 0);
    chk("e_u3_done", 32'(d3), 0);
    chk("e_u3_counts", 32'(p3 | f3 | i3), 0);
    chk("e_u3_ffv", 32'(v3), 0);
    chk("e_u3_errs", 32'(se3 | ce3), 0);
    chk("e_u1_all_zero", 32'(|{b1, d1, p1, f1, v1, i1, se1, ce1}), 0);
    chk("e_u4_all_zero", 32'(|{b4, d4, p4, f4, v4, i4, se4, ce4}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_all(mk(1, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0));
    pulse_start();
    txn(8'h0F, 8'hF0);
    pulse_stop();
    wait_done("e");

    // start and stop together from DONE: start wins.
    push_all(mk(1, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0));
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("f_u1_busy", 32'(b1), 1);
    chk("f_u1_not_done", 32'(d1), 0);
    chk("f_u1_pass_cleared", 32'(p1), 0);
    chk("f_u3_busy", 32'(b3), 1);
    @(negedge clk);
    chk("f_u1_still_busy", 32'(b1), 1);
    txn(8'h5A, 8'hA5);
    pulse_stop();
    wait_done("f");

    chk("q1_drained", 32'(q1.size()), 0);
    chk("q3_drained", 32'(q3.size()), 0);
    chk("q4_drained", 32'(q4.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
